frame_window_buffer: RTL

FRAME_WINDOW_BUFFER -- requirements
Module: frame_window_buffer

---
 rtl/frame_window_buffer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/frame_window_buffer.sv
// Double-buffered window capture: grabs a WIN_W x WIN_H window from an input raster into one bank
// while the display side reads the other; banks swap only on display vsync.
module frame_window_buffer #(
  parameter int PIX_W  = 36,
  parameter int LINE_W = 640,
  parameter int WIN_X0 = 0,
  parameter int WIN_Y0 = 0,
  parameter int WIN_W  = 128,
  parameter int WIN_H  = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_frame,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             freeze,
  input  logic             rd_valid,
  input  logic             rd_vsync,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_in_window,
  output logic             bank_ready,
  output logic [7:0]       frame_count
);

  localparam int DEPTH = WIN_W * WIN_H;
  localparam int XW    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] X_LO   = 32'(WIN_X0);
  localparam logic [31:0] Y_LO   = 32'(WIN_Y0);
  localparam logic [31:0] X_SPAN = 32'(WIN_W);
  localparam logic [31:0] Y_SPAN = 32'(WIN_H);
  localparam logic [31:0] X_LAST = 32'(LINE_W - 1);
  localparam logic [31:0] A_LAST = 32'(DEPTH - 1);

  // Unsigned offset compare: positions left of / above the window wrap to huge values.
  function automatic logic in_win(input logic [XW-1:0] x, input logic [9:0] y);
    return ((32'(x) - X_LO) < X_SPAN) && ((32'(y) - Y_LO) < Y_SPAN);
  endfunction

  logic [PIX_W-1:0] mem0_r [DEPTH];
  logic [PIX_W-1:0] mem1_r [DEPTH];

  logic [XW-1:0]    wx_r, rx_r;
  logic [9:0]       wy_r, ry_r;
  logic [AW-1:0]    waddr_r, raddr_r;
  logic             wbank_r, armed_r, capture_done_r, swap_pending_r, bank_ready_r;
  logic [7:0]       frame_count_r;
  logic             v1_r, win1_r, rdy1_r, sel1_r;
  logic [PIX_W-1:0] rd0_r, rd1_r;
  logic             out_valid_r, out_in_window_r;
  logic [PIX_W-1:0] out_pixel_r;

  logic             w_win_s, r_win_s, w_en_s, r_acc_s, swap_s;
  logic [PIX_W-1:0] rd_word_s;

  // Window decode, write/read qualification and masked read-data select.
  always_comb begin
    w_win_s   = in_win(wx_r, wy_r);
    r_win_s   = in_win(rx_r, ry_r);
    w_en_s    = in_valid && !in_frame && armed_r && w_win_s;
    r_acc_s   = rd_valid && !rd_vsync;
    swap_s    = rd_vsync && swap_pending_r;
    rd_word_s = '0;
    if (win1_r && rdy1_r) begin
      rd_word_s = sel1_r ? rd1_r : rd0_r;
    end else begin
      rd_word_s = '0;
    end
  end

  // Write raster tracking; armed stays low after reset until a fresh in_frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      wx_r           <= '0;
      wy_r           <= '0;
      waddr_r        <= '0;
      armed_r        <= 1'b0;
      capture_done_r <= 1'b0;
    end else if (in_frame) begin
      wx_r           <= '0;
      wy_r           <= '0;
      waddr_r        <= '0;
      armed_r        <= 1'b1;
      capture_done_r <= 1'b0;
    end else if (in_valid) begin
      if (w_en_s) begin
        waddr_r <= waddr_r + AW'(1);
        if (32'(waddr_r) == A_LAST) capture_done_r <= 1'b1;
      end
      if (32'(wx_r) == X_LAST) begin
        wx_r <= '0;
        if (wy_r != 10'd1023) wy_r <= wy_r + 10'd1;
      end else begin
        wx_r <= wx_r + XW'(1);
      end
    end
  end

  // Swap control: a request raised this cycle only takes effect at a later vsync.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbank_r        <= 1'b0;
      swap_pending_r <= 1'b0;
      bank_ready_r   <= 1'b0;
      frame_count_r  <= 8'd0;
    end else begin
      if (in_frame && capture_done_r && !freeze) begin
        swap_pending_r <= 1'b1;
      end else if (swap_s) begin
        swap_pending_r <= 1'b0;
      end
      if (swap_s) begin
        wbank_r       <= ~wbank_r;
        bank_ready_r  <= 1'b1;
        frame_count_r <= frame_count_r + 8'd1;
      end
    end
  end

  // Bank 0 write port.
  always_ff @(posedge clk) begin
    if (!reset && w_en_s && !wbank_r) mem0_r[waddr_r] <= in_pixel;
  end

  // Bank 1 write port.
  always_ff @(posedge clk) begin
    if (!reset && w_en_s && wbank_r) mem1_r[waddr_r] <= in_pixel;
  end

  // Registered read ports of both banks; the bank select is pipelined alongside.
  always_ff @(posedge clk) begin
    rd0_r <= mem0_r[raddr_r];
    rd1_r <= mem1_r[raddr_r];
  end

  // Display raster tracking.
  always_ff @(posedge clk) begin
    if (reset || rd_vsync) begin
      rx_r    <= '0;
      ry_r    <= '0;
      raddr_r <= '0;
    end else if (rd_valid) begin
      if (r_win_s) raddr_r <= raddr_r + AW'(1);
      if (32'(rx_r) == X_LAST) begin
        rx_r <= '0;
        if (ry_r != 10'd1023) ry_r <= ry_r + 10'd1;
      end else begin
        rx_r <= rx_r + XW'(1);
      end
    end
  end

  // Two-stage read pipeline: request qualifiers, then masked output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_r            <= 1'b0;
      win1_r          <= 1'b0;
      rdy1_r          <= 1'b0;
      sel1_r          <= 1'b0;
      out_valid_r     <= 1'b0;
      out_in_window_r <= 1'b0;
      out_pixel_r     <= '0;
    end else begin
      v1_r            <= r_acc_s;
      win1_r          <= r_acc_s && r_win_s;
      rdy1_r          <= bank_ready_r;
      sel1_r          <= ~wbank_r;
      out_valid_r     <= v1_r;
      out_in_window_r <= win1_r;
      out_pixel_r     <= rd_word_s;
    end
  end

  assign out_valid     = out_valid_r;
  assign out_pixel     = out_pixel_r;
  assign out_in_window = out_in_window_r;
  assign bank_ready    = bank_ready_r;
  assign frame_count   = frame_count_r;

endmodule
